// File: rtl/alu_nbit_seq.sv
// Registered N-bit ALU with operand conditioning, AND/OR/NOT-B/ADD in one cycle,
// an iterative unsigned shift-add multiply, status flags and valid/ready handshakes.
module alu_nbit_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             invA,
  input  logic             enA,
  input  logic             enB,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             neg,
  output logic             err
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] MUL  = 1'b1;

  localparam logic [2:0] OP_AND  = 3'b000;
  localparam logic [2:0] OP_OR   = 3'b001;
  localparam logic [2:0] OP_NOTB = 3'b010;
  localparam logic [2:0] OP_ADD  = 3'b011;
  localparam logic [2:0] OP_MUL  = 3'b100;

  logic [0:0]       state_reg;
  logic [CW-1:0]    step_reg;
  logic [WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0] hi_reg;
  logic [WIDTH-1:0] lo_reg;

  logic [WIDTH-1:0] a_cond;
  logic [WIDTH-1:0] b_cond;
  logic [WIDTH:0]   add_sum;
  logic [WIDTH-1:0] alu_result;
  logic             alu_cout;
  logic             alu_ovf;
  logic             alu_err;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH-1:0] mul_hi_next;
  logic [WIDTH-1:0] mul_lo_next;

  logic accept;
  logic load_single;
  logic start_mul;
  logic mul_done;

  assign a_cond  = (A & {WIDTH{enA}}) ^ {WIDTH{invA}};
  assign b_cond  = B & {WIDTH{enB}};
  assign add_sum = {1'b0, a_cond} + {1'b0, b_cond} + {{WIDTH{1'b0}}, cin};

  always_comb begin
    alu_result = '0;
    alu_cout   = 1'b0;
    alu_ovf    = 1'b0;
    alu_err    = 1'b0;
    case (op)
      OP_AND:  alu_result = a_cond & b_cond;
      OP_OR:   alu_result = a_cond | b_cond;
      OP_NOTB: alu_result = ~b_cond;
      OP_ADD: begin
        alu_result = add_sum[WIDTH-1:0];
        alu_cout   = add_sum[WIDTH];
        alu_ovf    = (a_cond[WIDTH-1] == b_cond[WIDTH-1]) &&
                     (add_sum[WIDTH-1] != a_cond[WIDTH-1]);
      end
      OP_MUL:  alu_result = '0;
      default: alu_err = 1'b1;
    endcase
  end

  // One shift-add step: {hi,lo} holds the partial product with the unconsumed
  // multiplier bits in lo; the carry out of hi shifts back in at the top.
  assign mul_sum     = {1'b0, hi_reg} + ({1'b0, mcand_reg} & {(WIDTH+1){lo_reg[0]}});
  assign mul_hi_next = mul_sum[WIDTH:1];
  assign mul_lo_next = {mul_sum[0], lo_reg[WIDTH-1:1]};

  assign in_ready    = (state_reg == IDLE) && (!out_valid || out_ready);
  assign accept      = in_valid && in_ready;
  assign load_single = accept && (op != OP_MUL);
  assign start_mul   = accept && (op == OP_MUL);
  assign mul_done    = (state_reg == MUL) && (step_reg == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      step_reg  <= '0;
      mcand_reg <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_mul) begin
            state_reg <= MUL;
            step_reg  <= '0;
            mcand_reg <= a_cond;
            hi_reg    <= '0;
            lo_reg    <= b_cond;
          end
        end
        default: begin
          hi_reg   <= mul_hi_next;
          lo_reg   <= mul_lo_next;
          step_reg <= step_reg + 1'b1;
          if (mul_done) begin
            state_reg <= IDLE;
            step_reg  <= '0;
          end
        end
      endcase
    end
  end

  // A load always wins over a consume, so consume+load in one edge keeps out_valid high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      result_hi <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      neg       <= 1'b0;
      err       <= 1'b0;
    end else if (load_single) begin
      out_valid <= 1'b1;
      result    <= alu_result;
      result_hi <= '0;
      cout      <= alu_cout;
      ovf       <= alu_ovf;
      zero      <= (alu_result == '0);
      neg       <= alu_result[WIDTH-1];
      err       <= alu_err;
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_lo_next;
      result_hi <= mul_hi_next;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= ({mul_hi_next, mul_lo_next} == '0);
      neg       <= mul_hi_next[WIDTH-1];
      err       <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_nbit_seq.sv
// Bench for alu_nbit_seq (WIDTH=8): directed vectors plus randomized ops checked
// against an arithmetic reference model, including latency and handshake behaviour.
module tb_alu_nbit_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic         invA = 1'b0;
  logic         enA = 1'b1;
  logic         enB = 1'b1;
  logic         cin = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic [W-1:0] result_hi;
  logic         cout;
  logic         ovf;
  logic         zero;
  logic         neg;
  logic         err;

  logic [2*W+4:0] obs_now;
  assign obs_now = {result_hi, result, cout, ovf, zero, neg, err};

  int compared = 0;
  int mismatched = 0;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .A(A), .B(B), .invA(invA), .enA(enA), .enB(enB), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .result_hi(result_hi), .cout(cout), .ovf(ovf), .zero(zero), .neg(neg), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [2*W+4:0] pack(input logic [7:0] rh, input logic [7:0] r,
                                          input logic c, v, z, n, e);
    return {rh, r, c, v, z, n, e};
  endfunction

  // Reference: plain integer arithmetic on the conditioned operands.
  function automatic logic [2*W+4:0] model(input logic [2:0] o, input logic [7:0] a, b,
                                           input logic ia, ea, eb, ci);
    logic [7:0] a1, b1, r, rh;
    logic c, v, e;
    int s, ss;
    logic [15:0] p;
    a1 = ea ? a : 8'h00;
    if (ia) a1 = ~a1;
    b1 = eb ? b : 8'h00;
    r = 0; rh = 0; c = 0; v = 0; e = 0;
    case (o)
      3'd0: r = a1 & b1;
      3'd1: r = a1 | b1;
      3'd2: r = ~b1;
      3'd3: begin
        s  = int'(a1) + int'(b1) + int'(ci);
        r  = s[7:0];
        c  = (s > 255);
        ss = int'($signed(a1)) + int'($signed(b1)) + int'(ci);
        v  = (ss > 127) || (ss < -128);
      end
      3'd4: begin
        p  = 16'(a1) * 16'(b1);
        r  = p[7:0];
        rh = p[15:8];
      end
      default: e = 1'b1;
    endcase
    return pack(rh, r, c, v, ({rh, r} == 16'h0), (o == 3'd4) ? rh[7] : r[7], e);
  endfunction

  // Issues one op, then waits (bounded) for its result; returns observations.
  task automatic run_op(input logic [2:0] o, input logic [7:0] a, b,
                        input logic ia, ea, eb, ci,
                        output logic [2*W+4:0] obs, output int lat, output int busy,
                        output bit ok);
    int n;
    op = o; A = a; B = b; invA = ia; enA = ea; enB = eb; cin = ci;
    in_valid = 1'b1;
    ok = 1; n = 0; lat = 0; busy = 0; obs = '0;
    @(negedge clk);
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      ok = 0;
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 3'($urandom); A = 8'($urandom); B = 8'($urandom);
    invA = 1'($urandom); enA = 1'($urandom); enB = 1'($urandom); cin = 1'($urandom);
    lat = 1;
    @(negedge clk);
    while (!out_valid && lat < 30) begin
      if (!in_ready) busy++;
      @(negedge clk);
      lat++;
    end
    obs = obs_now;
    if (!out_valid) ok = 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    in_valid = 1'b1; op = 3'd3; A = 8'hAA; B = 8'h55;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || obs_now !== '0) begin
      mismatched++;
      $display("FAIL reset_state: out_valid=%b outs=%h, required out_valid=0 outs=0", out_valid, obs_now);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL reset_release: in_ready=%b out_valid=%b, required 1/0", in_ready, out_valid);
    end
    $display("reset: checked");
  endtask

  task automatic test_add_sub_notb;
    logic [2*W+4:0] obs;
    int lat, busy;
    bit ok;
    logic [2*W+4:0] exp_v;
    run_op(3'd3, 8'h7F, 8'h01, 0, 1, 1, 0, obs, lat, busy, ok);
    exp_v = pack(8'h00, 8'h80, 0, 1, 0, 1, 0);
    compared++;
    if (!ok || obs !== exp_v || lat !== 1) begin
      mismatched++;
      $display("FAIL add_7f_01: got %h lat %0d, required %h lat 1", obs, lat, exp_v);
    end
    $display("add 7F+01: result=%h flags=%b", obs[12:5], obs[4:0]);
    run_op(3'd3, 8'h05, 8'h03, 1, 1, 1, 1, obs, lat, busy, ok);
    exp_v = pack(8'h00, 8'hFE, 0, 0, 0, 1, 0);
    compared++;
    if (!ok || obs !== exp_v || lat !== 1) begin
      mismatched++;
      $display("FAIL subtract_3_5: got %h lat %0d, required %h lat 1", obs, lat, exp_v);
    end
    $display("sub 03-05: result=%h flags=%b", obs[12:5], obs[4:0]);
    run_op(3'd2, 8'h5A, 8'hF0, 0, 0, 1, 0, obs, lat, busy, ok);
    exp_v = pack(8'h00, 8'h0F, 0, 0, 0, 0, 0);
    compared++;
    if (!ok || obs !== exp_v || lat !== 1) begin
      mismatched++;
      $display("FAIL notb_f0: got %h lat %0d, required %h lat 1", obs, lat, exp_v);
    end
    $display("notb F0: result=%h flags=%b", obs[12:5], obs[4:0]);
  endtask

  task automatic test_mul;
    logic [2*W+4:0] obs;
    int lat, busy;
    bit ok;
    logic [2*W+4:0] exp_v;
    run_op(3'd4, 8'hFF, 8'hFF, 0, 1, 1, 1, obs, lat, busy, ok);
    exp_v = pack(8'hFE, 8'h01, 0, 0, 0, 1, 0);
    compared++;
    if (!ok || obs !== exp_v) begin
      mismatched++;
      $display("FAIL mul_ff_ff: got %h, required %h", obs, exp_v);
    end
    compared++;
    if (lat !== W + 1 || busy !== W) begin
      mismatched++;
      $display("FAIL mul_latency: lat %0d busy %0d, required lat %0d busy %0d", lat, busy, W + 1, W);
    end
    $display("mul FF*FF: product=%h lat=%0d busy=%0d", obs[20:5], lat, busy);
    run_op(3'd4, 8'h12, 8'h00, 0, 1, 1, 0, obs, lat, busy, ok);
    exp_v = pack(8'h00, 8'h00, 0, 0, 1, 0, 0);
    compared++;
    if (!ok || obs !== exp_v || lat !== W + 1) begin
      mismatched++;
      $display("FAIL mul_zero: got %h lat %0d, required %h lat %0d", obs, lat, exp_v, W + 1);
    end
    $display("mul 12*00: product=%h zero=%b", obs[20:5], obs[2]);
  endtask

  task automatic test_illegal;
    logic [2*W+4:0] obs;
    int lat, busy;
    bit ok;
    logic [2*W+4:0] exp_v;
    run_op(3'b110, 8'h3C, 8'hC3, 0, 1, 1, 1, obs, lat, busy, ok);
    exp_v = pack(8'h00, 8'h00, 0, 0, 1, 0, 1);
    compared++;
    if (!ok || obs !== exp_v || lat !== 1) begin
      mismatched++;
      $display("FAIL illegal_op: got %h lat %0d, required %h lat 1", obs, lat, exp_v);
    end
    $display("illegal op 110: outs=%h", obs);
    run_op(3'd1, 8'h01, 8'h02, 0, 1, 1, 0, obs, lat, busy, ok);
    exp_v = pack(8'h00, 8'h03, 0, 0, 0, 0, 0);
    compared++;
    if (!ok || obs !== exp_v) begin
      mismatched++;
      $display("FAIL err_clear: got %h, required %h", obs, exp_v);
    end
    $display("legal after illegal: outs=%h", obs);
  endtask

  task automatic test_backpressure;
    logic [2*W+4:0] exp1, exp2;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    out_ready = 1'b0;
    op = 3'd0; A = 8'hF0; B = 8'h3C; invA = 0; enA = 1; enB = 1; cin = 0;
    in_valid = 1'b1;
    exp1 = pack(8'h00, 8'h30, 0, 0, 0, 0, 0);
    exp2 = pack(8'h00, 8'h0F, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    op = 3'd1; A = 8'h0F; B = 8'h01;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      compared++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || obs_now !== exp1) begin
        mismatched++;
        $display("FAIL backpressure_hold: out_valid=%b in_ready=%b outs=%h, required 1/0 %h",
                 out_valid, in_ready, obs_now, exp1);
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b1 || obs_now !== exp2) begin
      mismatched++;
      $display("FAIL backpressure_swap: out_valid=%b outs=%h, required 1 %h", out_valid, obs_now, exp2);
    end
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL backpressure_drain: out_valid=%b, required 0", out_valid);
    end
    $display("backpressure: held AND result then swapped to OR result");
  endtask

  task automatic test_reset_during_mul;
    int n;
    bit seen;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    op = 3'd4; A = 8'hFF; B = 8'hFF; invA = 0; enA = 1; enB = 1; cin = 0;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 30) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compared++;
    if (out_valid !== 1'b0 || obs_now !== '0) begin
      mismatched++;
      $display("FAIL mul_reset_outs: out_valid=%b outs=%h, required 0/0", out_valid, obs_now);
    end
    rst_n = 1'b1;
    @(negedge clk);
    compared++;
    if (in_ready !== 1'b1) begin
      mismatched++;
      $display("FAIL mul_reset_ready: in_ready=%b, required 1", in_ready);
    end
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) seen = 1;
    end
    compared++;
    if (seen !== 1'b0) begin
      mismatched++;
      $display("FAIL mul_reset_abort: out_valid rose=%b, required 0", seen);
    end
    $display("reset during mul: aborted");
  endtask

  task automatic test_back_to_back;
    logic [2*W+4:0] exp_q[$];
    logic [2*W+4:0] e;
    logic [2:0] o;
    out_ready = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        e = exp_q.pop_front();
        compared++;
        if (out_valid !== 1'b1 || in_ready !== 1'b1 || obs_now !== e) begin
          mismatched++;
          $display("FAIL back_to_back[%0d]: out_valid=%b in_ready=%b outs=%h, required 1/1 %h",
                   i - 1, out_valid, in_ready, obs_now, e);
        end
        $display("b2b op %0d: outs=%h", i - 1, obs_now);
      end
      if (i < 12) begin
        o = 3'($urandom_range(0, 6));
        if (o >= 3'd4) o = o + 3'd1;
        op = o; A = 8'($urandom); B = 8'($urandom);
        invA = 1'($urandom); enA = 1'($urandom); enB = 1'($urandom); cin = 1'($urandom);
        exp_q.push_back(model(op, A, B, invA, enA, enB, cin));
        in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_random;
    logic [2*W+4:0] obs, e;
    int lat, busy;
    bit ok;
    logic [2:0] o;
    logic [7:0] a, b;
    logic ia, ea, eb, ci;
    for (int i = 0; i < 40; i++) begin
      o = 3'($urandom); a = 8'($urandom); b = 8'($urandom);
      ia = 1'($urandom); ea = ($urandom_range(0, 3) != 0); eb = ($urandom_range(0, 3) != 0);
      ci = 1'($urandom);
      e = model(o, a, b, ia, ea, eb, ci);
      run_op(o, a, b, ia, ea, eb, ci, obs, lat, busy, ok);
      compared++;
      if (!ok || obs !== e || lat !== ((o == 3'd4) ? W + 1 : 1)) begin
        mismatched++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h ia=%b ea=%b eb=%b ci=%b: got %h lat %0d, required %h lat %0d",
                 i, o, a, b, ia, ea, eb, ci, obs, lat, e, (o == 3'd4) ? W + 1 : 1);
      end
      $display("rand %0d op=%0d a=%h b=%h: outs=%h lat=%0d", i, o, a, b, obs, lat);
    end
  endtask

  initial begin
    test_reset();
    test_add_sub_notb();
    test_mul();
    test_illegal();
    test_backpressure();
    test_reset_during_mul();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
